// File: rtl/regfile_init_dump_pkg.sv
// Shared definitions for the register-file init/dump sequencer.
//   - state_e         : sequencer states
//   - NUM_REGS        : number of architectural registers
//   - LAST_IDX        : highest register index walked by init and dump
//   - SP_IDX / SP_INIT: default stack-pointer index and its reset value
package regfile_init_dump_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned LAST_IDX = 31;
    localparam int unsigned SP_IDX   = 2;
    localparam int unsigned SP_INIT  = 1023;

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StDumpLoad,
        StDumpSend
    } state_e;

endpackage

// File: rtl/regfile_init_dump.sv
// Register-file sequencer between the core datapath and the register file.
// After reset it writes every register x1..x31 (x2 gets SP_INIT, the rest 0),
// then passes core traffic straight through. A dump request streams all 32
// registers out over a valid/ready port while the core is stalled.
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   core_*              core-side register-file request (rs1, rd, data, we)
//   core_stall          high while the sequencer owns the register-file ports
//   rf_*                register-file side (rs1, rd, writeData, regWrite, readData1)
//   init_done           level, high once the init walk has finished
//   dump_req            request a dump (pulse or level)
//   dump_valid/ready    dump beat handshake
//   dump_index/data     register index and value of the current beat
//   dump_done           one-cycle pulse after the last beat is accepted
module regfile_init_dump
    import regfile_init_dump_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned SP_IDX  = regfile_init_dump_pkg::SP_IDX,
    parameter int unsigned SP_INIT = regfile_init_dump_pkg::SP_INIT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] core_rs1,
    input  logic [ADDR_W-1:0] core_rd,
    input  logic [DATA_W-1:0] core_writeData,
    input  logic              core_regWrite,
    output logic              core_stall,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writeData,
    output logic              rf_regWrite,
    input  logic [DATA_W-1:0] rf_readData1,
    output logic              init_done,
    input  logic              dump_req,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(LAST_IDX);
    localparam logic [ADDR_W-1:0] SpIdx   = ADDR_W'(SP_IDX);
    localparam logic [DATA_W-1:0] SpInit  = DATA_W'(SP_INIT);

    state_e            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic              r_init_done;
    logic              r_dump_valid;
    logic [ADDR_W-1:0] r_dump_index;
    logic [DATA_W-1:0] r_dump_data;
    logic              r_dump_done;
    logic              r_pending;

    state_e            w_state_next;
    logic [ADDR_W-1:0] w_idx_next;
    logic              w_init_done_next;
    logic              w_dump_valid_next;
    logic [ADDR_W-1:0] w_dump_index_next;
    logic [DATA_W-1:0] w_dump_data_next;
    logic              w_dump_done_next;
    logic              w_pending_next;

    // Next-state logic.
    always_comb begin
        w_state_next      = r_state;
        w_idx_next        = r_idx;
        w_init_done_next  = r_init_done;
        w_dump_valid_next = r_dump_valid;
        w_dump_index_next = r_dump_index;
        w_dump_data_next  = r_dump_data;
        w_dump_done_next  = 1'b0;
        w_pending_next    = r_pending;

        unique case (r_state)
            StInit: begin
                // A request that arrives mid-walk is remembered, not dropped.
                if (dump_req) w_pending_next = 1'b1;
                if (r_idx == LastIdx) begin
                    w_state_next     = StIdle;
                    w_init_done_next = 1'b1;
                end else begin
                    w_idx_next = r_idx + 1'b1;
                end
            end
            StIdle: begin
                if (dump_req || r_pending) begin
                    w_idx_next     = '0;
                    w_pending_next = 1'b0;
                    w_state_next   = StDumpLoad;
                end
            end
            StDumpLoad: begin
                if (dump_req) w_pending_next = 1'b1;
                w_dump_data_next  = rf_readData1;
                w_dump_index_next = r_idx;
                w_dump_valid_next = 1'b1;
                w_state_next      = StDumpSend;
            end
            StDumpSend: begin
                if (dump_req) w_pending_next = 1'b1;
                if (r_dump_valid && dump_ready) begin
                    w_dump_valid_next = 1'b0;
                    if (r_idx == LastIdx) begin
                        w_dump_done_next = 1'b1;
                        w_state_next     = StIdle;
                    end else begin
                        w_idx_next   = r_idx + 1'b1;
                        w_state_next = StDumpLoad;
                    end
                end
            end
            default: w_state_next = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= StInit;
            r_idx        <= ADDR_W'(1);
            r_init_done  <= 1'b0;
            r_dump_valid <= 1'b0;
            r_dump_index <= '0;
            r_dump_data  <= '0;
            r_dump_done  <= 1'b0;
            r_pending    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_idx        <= w_idx_next;
            r_init_done  <= w_init_done_next;
            r_dump_valid <= w_dump_valid_next;
            r_dump_index <= w_dump_index_next;
            r_dump_data  <= w_dump_data_next;
            r_dump_done  <= w_dump_done_next;
            r_pending    <= w_pending_next;
        end
    end

    // Register-file port mux. Reset is applied combinationally here so the
    // register file never sees a write while reset_n is low, whatever the
    // state register still holds.
    always_comb begin
        core_stall   = 1'b1;
        rf_rs1       = r_idx;
        rf_rd        = r_idx;
        rf_writeData = '0;
        rf_regWrite  = 1'b0;
        if (reset_n) begin
            unique case (r_state)
                StInit: begin
                    rf_regWrite  = 1'b1;
                    rf_writeData = (r_idx == SpIdx) ? SpInit : '0;
                end
                StIdle: begin
                    core_stall   = 1'b0;
                    rf_rs1       = core_rs1;
                    rf_rd        = core_rd;
                    rf_writeData = core_writeData;
                    rf_regWrite  = core_regWrite;
                end
                default: ;
            endcase
        end
    end

    assign init_done  = r_init_done;
    assign dump_valid = r_dump_valid;
    assign dump_index = r_dump_index;
    assign dump_data  = r_dump_data;
    assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_regfile_init_dump.sv
// Bench for regfile_init_dump with a behavioural register file attached.
// Expected init writes and dump beats are queued by the stimulus; monitors
// compare them against what the DUT presents.
module tb_regfile_init_dump;
    import regfile_init_dump_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] core_rs1;
    logic [AW-1:0] core_rd;
    logic [DW-1:0] core_writeData;
    logic          core_regWrite;
    logic          core_stall;
    logic [AW-1:0] rf_rs1;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_writeData;
    logic          rf_regWrite;
    logic [DW-1:0] rf_readData1;
    logic          init_done;
    logic          dump_req;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_index;
    logic [DW-1:0] dump_data;
    logic          dump_done;

    regfile_init_dump #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .SP_IDX (2),
        .SP_INIT(1023)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_rs1      (core_rs1),
        .core_rd       (core_rd),
        .core_writeData(core_writeData),
        .core_regWrite (core_regWrite),
        .core_stall    (core_stall),
        .rf_rs1        (rf_rs1),
        .rf_rd         (rf_rd),
        .rf_writeData  (rf_writeData),
        .rf_regWrite   (rf_regWrite),
        .rf_readData1  (rf_readData1),
        .init_done     (init_done),
        .dump_req      (dump_req),
        .dump_valid    (dump_valid),
        .dump_ready    (dump_ready),
        .dump_index    (dump_index),
        .dump_data     (dump_data),
        .dump_done     (dump_done)
    );

    always #5 clk = ~clk;

    // Behavioural register file: x0 reads zero, combinational read.
    logic [DW-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (rf_regWrite && rf_rd != '0) rf_mem[rf_rd] <= rf_writeData;
    end
    assign rf_readData1 = (rf_rs1 == '0) ? '0 : rf_mem[rf_rs1];

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [DW-1:0] data;
    } item_t;

    item_t         exp_wr_q[$];
    item_t         exp_beat_q[$];
    logic [DW-1:0] exp_regs[32];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_beat_cyc = 0;
    int req_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Sequencer-owned writes (core stalled) must match the init queue.
    always @(negedge clk) begin
        if (rf_regWrite && core_stall) begin
            if (exp_wr_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: rd=%0d data=0x%08h", rf_rd, rf_writeData);
            end else begin
                check("init_wr_rd", 32'(rf_rd), 32'(exp_wr_q[0].idx));
                check("init_wr_data", rf_writeData, exp_wr_q[0].data);
                void'(exp_wr_q.pop_front());
            end
        end
    end

    // Every valid cycle, stalled or not, must show the head beat.
    always @(negedge clk) begin
        if (dump_valid) begin
            if (exp_beat_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: index=%0d data=0x%08h", dump_index, dump_data);
            end else begin
                check("beat_index", 32'(dump_index), 32'(exp_beat_q[0].idx));
                check("beat_data", dump_data, exp_beat_q[0].data);
                if (dump_ready) begin
                    void'(exp_beat_q.pop_front());
                    last_beat_cyc = cyc;
                end
            end
        end
        if (dump_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic reset_model();
        for (int i = 0; i < 32; i++) exp_regs[i] = '0;
        exp_regs[2] = 32'd1023;
    endtask

    task automatic push_dump(input int n);
        for (int i = 0; i < n; i++) exp_beat_q.push_back({AW'(i), exp_regs[i]});
    endtask

    // Release reset and follow the 31-cycle init walk; optional dump pulse at cycle req_at.
    task automatic run_init(input int req_at);
        for (int i = 1; i < 32; i++) exp_wr_q.push_back({AW'(i), (i == 2) ? 32'd1023 : 32'd0});
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (c <= 31) begin
                check("init_stall", 32'(core_stall), 32'd1);
                check("init_done_low", 32'(init_done), 32'd0);
                check("init_we", 32'(rf_regWrite), 32'd1);
            end
            if (c == 31) check("no_beat_in_init", 32'(dump_valid), 32'd0);
            if (c == 32) begin
                check("init_done_high", 32'(init_done), 32'd1);
                check("idle_stall", 32'(core_stall), 32'd0);
                check("init_wr_left", 32'(exp_wr_q.size()), 32'd0);
            end
            if (c == req_at) dump_req = 1'b1;
            if (c == req_at + 1) dump_req = 1'b0;
        end
    endtask

    task automatic pulse_req();
        @(posedge clk);
        #1 dump_req = 1'b1;
        req_cyc = cyc;
        @(posedge clk);
        #1 dump_req = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        for (int c = 0; c < 300 && done_cnt == prev; c++) @(negedge clk);
        check("dump_done_count", 32'(done_cnt), 32'(prev + 1));
        repeat (3) @(negedge clk);
        check("dump_done_single", 32'(done_cnt), 32'(prev + 1));
        check("beats_left", 32'(exp_beat_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int prev;
        bit found;
        reset_n        = 1'b0;
        core_rs1       = '0;
        core_rd        = '0;
        core_writeData = '0;
        core_regWrite  = 1'b0;
        dump_req       = 1'b0;
        dump_ready     = 1'b0;
        reset_model();

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_dump_index", 32'(dump_index), 32'd0);
        check("rst_dump_data", dump_data, 32'd0);
        check("rst_dump_done", 32'(dump_done), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd1);
        check("rst_we", 32'(rf_regWrite), 32'd0);

        // Init walk, then a full dump with ready held high.
        run_init(0);
        dump_ready = 1'b1;
        push_dump(32);
        prev = done_cnt;
        pulse_req();
        wait_done(prev);
        check("last_beat_latency", 32'(last_beat_cyc - req_cyc), 32'd64);
        check("done_latency", 32'(done_cyc - req_cyc), 32'd65);

        // Core write passthrough, then dump with ready pattern 0/0/1.
        @(posedge clk);
        #1 core_rs1 = 5'd5; core_rd = 5'd5; core_writeData = 32'hDEADBEEF; core_regWrite = 1'b1;
        @(negedge clk);
        check("pass_rs1", 32'(rf_rs1), 32'd5);
        check("pass_rd", 32'(rf_rd), 32'd5);
        check("pass_wdata", rf_writeData, 32'hDEADBEEF);
        check("pass_we", 32'(rf_regWrite), 32'd1);
        @(posedge clk);
        #1 core_regWrite = 1'b0;
        exp_regs[5] = 32'hDEADBEEF;
        dump_ready = 1'b0;
        push_dump(32);
        prev = done_cnt;
        pulse_req();
        for (int c = 0; c < 300 && done_cnt == prev; c++) begin
            @(posedge clk);
            #1 dump_ready = (c % 3 == 2);
        end
        dump_ready = 1'b1;
        wait_done(prev);

        // Reset, dump request during init is deferred until init completes.
        @(posedge clk);
        #1 reset_n = 1'b0;
        reset_model();
        push_dump(32);
        prev = done_cnt;
        run_init(10);
        @(negedge clk);
        check("deferred_load_valid", 32'(dump_valid), 32'd0);
        check("deferred_load_stall", 32'(core_stall), 32'd1);
        @(negedge clk);
        check("deferred_first_valid", 32'(dump_valid), 32'd1);
        check("deferred_first_index", 32'(dump_index), 32'd0);
        wait_done(prev);

        // Reset during beat 12 abandons the dump without dump_done.
        push_dump(13);
        prev = done_cnt;
        pulse_req();
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (dump_valid && dump_index == 5'd12) found = 1'b1;
        end
        check("beat12_seen", 32'(found), 32'd1);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_stall", 32'(core_stall), 32'd1);
        check("abort_we", 32'(rf_regWrite), 32'd0);
        run_init(0);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(done_cnt), 32'(prev));
        check("abort_beats_left", 32'(exp_beat_q.size()), 32'd0);

        // Core writes during a dump are blocked.
        push_dump(32);
        prev = done_cnt;
        pulse_req();
        core_rd = 5'd7; core_writeData = 32'h12345678; core_regWrite = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            check("dump_block_we", 32'(rf_regWrite), 32'd0);
            check("dump_block_stall", 32'(core_stall), 32'd1);
        end
        @(posedge clk);
        #1 core_regWrite = 1'b0;
        wait_done(prev);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
